// File: rtl/sample_ram_arb.sv
// sample_ram_arb: shares one single-port sample RAM between a write-only
// sniffer master and a read/write host master, both pipelined Wishbone.
// The sniffer is granted by default; the host is granted when the sniffer is
// idle. Build option SAMPLE_RAM_ARB_FAIRNESS_EN adds a starvation counter.
// With it, after STARVE_MAX consecutive sniffer grants against a waiting
// host, the host wins one cycle. Without it, the sniffer has strict priority.
module sample_ram_arb #(
  parameter int ADDR_W     = 10,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  // sniffer master (write-only)
  input  logic [31:0]       snf_addr_i,
  input  logic [31:0]       snf_data_i,
  input  logic [3:0]        snf_sel_i,
  input  logic              snf_we_i,
  input  logic              snf_stb_i,
  output logic              snf_stall_o,
  output logic              snf_ack_o,
  // host master (read/write)
  input  logic [31:0]       host_addr_i,
  input  logic [31:0]       host_data_i,
  input  logic [3:0]        host_sel_i,
  input  logic              host_we_i,
  input  logic              host_cyc_i,
  input  logic              host_stb_i,
  output logic [31:0]       host_data_o,
  output logic              host_stall_o,
  output logic              host_ack_o,
  // single-port RAM
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [3:0]        ram_be_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  input  logic [31:0]       ram_rdata_i
);

  logic snf_req;
  logic host_req;
  logic snf_gnt;
  logic host_gnt;
  logic force_host;
  logic snf_ack_q;
  logic snf_ack_d;
  logic host_ack_q;
  logic host_ack_d;

  assign snf_req  = snf_stb_i;
  assign host_req = host_cyc_i & host_stb_i;

`ifdef SAMPLE_RAM_ARB_FAIRNESS_EN
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] starve_q;
  logic [STARVE_W-1:0] starve_d;

  assign force_host = (starve_q == STARVE_LIM);

  // Count sniffer wins against a waiting host; clear once the host is served or gives up.
  always_comb begin
    starve_d = starve_q;
    if (!host_req || host_gnt) begin
      starve_d = '0;
    end else if (snf_gnt && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  logic unused_cfg;

  assign force_host = 1'b0;
  assign unused_cfg = (STARVE_MAX > 0);
`endif

  // Combinational grant in the request cycle: at most one master, none in reset.
  always_comb begin
    snf_gnt  = 1'b0;
    host_gnt = 1'b0;
    if (rst_n_i) begin
      if (snf_req && !(host_req && force_host)) begin
        snf_gnt = 1'b1;
      end else if (host_req) begin
        host_gnt = 1'b1;
      end
    end
  end

  assign snf_stall_o  = snf_req & ~snf_gnt;
  assign host_stall_o = host_req & ~host_gnt;

  // RAM port mux: sniffer fields only while it holds the grant, host fields otherwise.
  always_comb begin
    ram_en_o    = snf_gnt | host_gnt;
    ram_we_o    = 1'b0;
    ram_be_o    = host_sel_i;
    ram_addr_o  = host_addr_i[ADDR_W+1:2];
    ram_wdata_o = host_data_i;
    if (snf_gnt) begin
      ram_we_o    = snf_we_i;
      ram_be_o    = snf_sel_i;
      ram_addr_o  = snf_addr_i[ADDR_W+1:2];
      ram_wdata_o = snf_data_i;
    end else if (host_gnt) begin
      ram_we_o = host_we_i;
    end
  end

  assign snf_ack_d  = snf_gnt;
  assign host_ack_d = host_gnt;

  // Acks are a one-cycle delayed copy of the grant, independent of later cyc/stb.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      snf_ack_q  <= 1'b0;
      host_ack_q <= 1'b0;
    end else begin
      snf_ack_q  <= snf_ack_d;
      host_ack_q <= host_ack_d;
    end
  end

  assign snf_ack_o   = snf_ack_q;
  assign host_ack_o  = host_ack_q;
  assign host_data_o = host_ack_q ? ram_rdata_i : '0;

  logic unused_bits;
  assign unused_bits = ^{snf_addr_i[31:ADDR_W+2], snf_addr_i[1:0],
                         host_addr_i[31:ADDR_W+2], host_addr_i[1:0]};

endmodule

// File: tb/tb_sample_ram_arb.sv
module tb_sample_ram_arb;

  localparam int ADDR_W = 10;

  logic              clk;
  logic              rst_n;
  logic [31:0]       snf_addr;
  logic [31:0]       snf_data;
  logic [3:0]        snf_sel;
  logic              snf_we;
  logic              snf_stb;
  logic              snf_stall;
  logic              snf_ack;
  logic [31:0]       host_addr;
  logic [31:0]       host_wdata;
  logic [3:0]        host_sel;
  logic              host_we;
  logic              host_cyc;
  logic              host_stb;
  logic [31:0]       host_rdata;
  logic              host_stall;
  logic              host_ack;
  logic              ram_en;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  int checks;
  int failures;

  sample_ram_arb #(.ADDR_W(ADDR_W), .STARVE_MAX(4)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .snf_addr_i  (snf_addr),
    .snf_data_i  (snf_data),
    .snf_sel_i   (snf_sel),
    .snf_we_i    (snf_we),
    .snf_stb_i   (snf_stb),
    .snf_stall_o (snf_stall),
    .snf_ack_o   (snf_ack),
    .host_addr_i (host_addr),
    .host_data_i (host_wdata),
    .host_sel_i  (host_sel),
    .host_we_i   (host_we),
    .host_cyc_i  (host_cyc),
    .host_stb_i  (host_stb),
    .host_data_o (host_rdata),
    .host_stall_o(host_stall),
    .host_ack_o  (host_ack),
    .ram_en_o    (ram_en),
    .ram_we_o    (ram_we),
    .ram_be_o    (ram_be),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM, byte-enabled write, one-cycle read latency.
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    snf_stb  = 1'b0;
    snf_we   = 1'b0;
    host_cyc = 1'b0;
    host_stb = 1'b0;
    host_we  = 1'b0;
  endtask

  initial begin
    logic exp_h;
    logic [31:0] rd;
    checks     = 0;
    failures   = 0;
    ram_rdata  = '0;
    rst_n      = 1'b0;
    snf_addr   = '0;
    snf_data   = '0;
    snf_sel    = '0;
    host_addr  = '0;
    host_wdata = '0;
    host_sel   = '0;
    idle_inputs();

    // Reset: both requesting, no grant, stall follows request.
    @(negedge clk);
    snf_stb = 1'b1; host_cyc = 1'b1; host_stb = 1'b1;
    #1;
    check("rst_ram_en",     32'(ram_en),     32'd0);
    check("rst_ram_we",     32'(ram_we),     32'd0);
    check("rst_snf_stall",  32'(snf_stall),  32'd1);
    check("rst_host_stall", 32'(host_stall), 32'd1);
    @(posedge clk); #1;
    check("rst_snf_ack",    32'(snf_ack),    32'd0);
    check("rst_host_ack",   32'(host_ack),   32'd0);
    check("rst_host_data",  host_rdata,      32'd0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;

    // Sniffer full-word write to 0x10.
    @(negedge clk);
    snf_addr = 32'h0000_0010; snf_data = 32'hDEAD_BEEF; snf_sel = 4'hF;
    snf_we = 1'b1; snf_stb = 1'b1;
    #1;
    check("w_ram_addr",  32'(ram_addr),  32'd4);
    check("w_ram_we",    32'(ram_we),    32'd1);
    check("w_ram_en",    32'(ram_en),    32'd1);
    check("w_ram_wdata", ram_wdata,      32'hDEAD_BEEF);
    check("w_snf_stall", 32'(snf_stall), 32'd0);
    @(posedge clk); #1;
    check("w_snf_ack1",  32'(snf_ack),   32'd1);
    @(negedge clk);
    idle_inputs();
    @(posedge clk); #1;
    check("w_snf_ack2",  32'(snf_ack),   32'd0);

    // Host read of 0x10 with sniffer idle.
    @(negedge clk);
    host_addr = 32'h10; host_we = 1'b0; host_sel = 4'hF;
    host_cyc = 1'b1; host_stb = 1'b1;
    #1;
    check("r_host_stall", 32'(host_stall), 32'd0);
    check("r_ram_we",     32'(ram_we),     32'd0);
    check("r_ram_addr",   32'(ram_addr),   32'd4);
    @(posedge clk); #1;
    check("r_host_ack",   32'(host_ack),   32'd1);
    check("r_host_data",  host_rdata,      32'hDEAD_BEEF);
    @(negedge clk);
    idle_inputs();
    @(posedge clk); #1;
    check("r_host_ack0",  32'(host_ack),   32'd0);
    check("r_host_data0", host_rdata,      32'd0);

    // Host byte write to 0x20 followed back-to-back by a read.
    @(negedge clk);
    host_addr = 32'h20; host_wdata = 32'h0000_AB00; host_sel = 4'h2;
    host_we = 1'b1; host_cyc = 1'b1; host_stb = 1'b1;
    #1;
    check("bw_ram_be",   32'(ram_be),   32'h2);
    check("bw_ram_addr", 32'(ram_addr), 32'd8);
    check("bw_ram_we",   32'(ram_we),   32'd1);
    @(negedge clk);
    host_we = 1'b0; host_sel = 4'hF;
    #1;
    check("bw_ack_w",    32'(host_ack), 32'd1);
    check("br_stall",    32'(host_stall), 32'd0);
    @(posedge clk); #1;
    check("br_ack",      32'(host_ack), 32'd1);
    rd = host_rdata;
    check("br_byte1",    32'(rd[15:8]), 32'hAB);
    @(negedge clk);
    idle_inputs();

    // Both masters requesting continuously.
    @(negedge clk);
    snf_addr = 32'h40; snf_data = 32'h1234_5678; snf_sel = 4'hF; snf_we = 1'b1; snf_stb = 1'b1;
    host_addr = 32'h10; host_we = 1'b0; host_cyc = 1'b1; host_stb = 1'b1;
    #1;
    check("both_ram_addr", 32'(ram_addr), 32'h10);
    check("both_ram_we",   32'(ram_we),   32'd1);
    for (int i = 0; i < 10; i++) begin
`ifdef SAMPLE_RAM_ARB_FAIRNESS_EN
      exp_h = ((i % 5) == 4);
`else
      exp_h = 1'b0;
`endif
      if (i != 0) begin
        @(negedge clk); #1;
      end
      check($sformatf("both_snf_stall%0d", i),  32'(snf_stall),  32'(exp_h));
      check($sformatf("both_host_stall%0d", i), 32'(host_stall), 32'(!exp_h));
      @(posedge clk); #1;
      check($sformatf("both_host_ack%0d", i),   32'(host_ack),   32'(exp_h));
      check($sformatf("both_snf_ack%0d", i),    32'(snf_ack),    32'(!exp_h));
    end
    @(negedge clk);
    idle_inputs();

    // Host drops cyc in the ack cycle; the ack stands.
    @(negedge clk);
    host_addr = 32'h10; host_cyc = 1'b1; host_stb = 1'b1;
    @(negedge clk);
    host_cyc = 1'b0; host_stb = 1'b0;
    #1;
    check("drop_host_ack",  32'(host_ack),   32'd1);
    check("drop_host_data", host_rdata,      32'hDEAD_BEEF);

    // Reset one cycle after a sniffer acceptance.
    @(negedge clk);
    snf_addr = 32'h44; snf_we = 1'b1; snf_stb = 1'b1;
    host_cyc = 1'b1; host_stb = 1'b1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mr_snf_ack",   32'(snf_ack),   32'd0);
    check("mr_ram_en",    32'(ram_en),    32'd0);
    check("mr_snf_stall", 32'(snf_stall), 32'd1);
`ifdef SAMPLE_RAM_ARB_FAIRNESS_EN
    check("mr_starve",    32'(dut.starve_q), 32'd0);
`endif
    @(posedge clk); #1;
    check("mr_snf_ack2",  32'(snf_ack),   32'd0);
    check("mr_ram_en2",   32'(ram_en),    32'd0);
    @(negedge clk);
    host_cyc = 1'b0; host_stb = 1'b0;
    rst_n = 1'b1;
    #1;
    check("rel_ram_en",   32'(ram_en),    32'd1);
    @(posedge clk); #1;
    check("rel_snf_ack",  32'(snf_ack),   32'd1);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
